// File: rtl/cpu_mem_arbiter_pkg.sv
// cpu_mem_arbiter_pkg: shared word type plus arbiter state, port and request types.
package rv32i_types;
    typedef logic [31:0] rv32i_word;
endpackage

package arbiter_types;
    import rv32i_types::*;

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} arb_state_t;
    typedef enum logic {PORT_I, PORT_D} arb_port_t;

    typedef struct packed {
        logic       read;
        logic       write;
        logic [3:0] byte_enable;
        rv32i_word  address;
        rv32i_word  wdata;
    } mem_req_t;
endpackage

// File: rtl/cpu_mem_arbiter_select.sv
// arb_req_select: picks which CPU port to grant from IDLE, round-robin on a tie,
// and normalises a read+write request into a plain write.
module arb_req_select
    import arbiter_types::*;
(
    input  mem_req_t   i_req_i,
    input  mem_req_t   i_req_d,
    input  arb_port_t  i_last_grant,
    input  arb_state_t i_state,
    output logic       o_grant_valid,
    output arb_port_t  o_grant_port,
    output mem_req_t   o_sel
);
    logic     w_pend_i;
    logic     w_pend_d;
    mem_req_t w_raw;

    assign w_pend_i = i_req_i.read | i_req_i.write;
    assign w_pend_d = i_req_d.read | i_req_d.write;

    always_comb begin
        o_grant_valid = (i_state == IDLE) && (w_pend_i || w_pend_d);
        o_grant_port  = (w_pend_i && w_pend_d) ? ((i_last_grant == PORT_D) ? PORT_I : PORT_D)
                                               : (w_pend_i ? PORT_I : PORT_D);
        w_raw         = (o_grant_port == PORT_I) ? i_req_i : i_req_d;
        o_sel         = w_raw;
        o_sel.read    = w_raw.read & ~w_raw.write;
    end
endmodule

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: serialises the CPU instruction and data memory ports onto one
// registered downstream port, one transaction at a time, round-robin on contention.
module cpu_mem_arbiter
    import arbiter_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [3:0]  i_mem_byte_enable,
    input  logic [31:0] i_mem_address,
    input  logic [31:0] i_mem_wdata,
    output logic        i_mem_resp,
    output logic [31:0] i_mem_rdata,
    input  logic        d_mem_read,
    input  logic        d_mem_write,
    input  logic [3:0]  d_mem_byte_enable,
    input  logic [31:0] d_mem_address,
    input  logic [31:0] d_mem_wdata,
    output logic        d_mem_resp,
    output logic [31:0] d_mem_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata
);
    arb_state_t r_state;
    arb_state_t w_next;
    arb_port_t  r_last_grant;
    arb_port_t  w_grant_port;
    mem_req_t   r_req;
    mem_req_t   w_req_i;
    mem_req_t   w_req_d;
    mem_req_t   w_sel;
    logic       w_grant_valid;
    logic       w_resp_hit;

    assign w_req_i = '{read: i_mem_read, write: i_mem_write, byte_enable: i_mem_byte_enable,
                       address: i_mem_address, wdata: i_mem_wdata};
    assign w_req_d = '{read: d_mem_read, write: d_mem_write, byte_enable: d_mem_byte_enable,
                       address: d_mem_address, wdata: d_mem_wdata};

    arb_req_select u_select (
        .i_req_i       (w_req_i),
        .i_req_d       (w_req_d),
        .i_last_grant  (r_last_grant),
        .i_state       (r_state),
        .o_grant_valid (w_grant_valid),
        .o_grant_port  (w_grant_port),
        .o_sel         (w_sel)
    );

    // DONE falls to the default arm: one dead cycle so a held old request is not re-served.
    always_comb begin
        w_next     = r_state;
        i_mem_resp = 1'b0;
        d_mem_resp = 1'b0;
        case (r_state)
            IDLE:    w_next = w_grant_valid ? ((w_grant_port == PORT_I) ? SERVE_I : SERVE_D) : IDLE;
            SERVE_I: begin
                i_mem_resp = mem_resp;
                w_next     = mem_resp ? DONE : SERVE_I;
            end
            SERVE_D: begin
                d_mem_resp = mem_resp;
                w_next     = mem_resp ? DONE : SERVE_D;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_resp_hit = i_mem_resp | d_mem_resp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= PORT_D;
            r_req        <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant_valid) begin
                r_req <= w_sel;
            end else if (w_resp_hit) begin
                r_req.read   <= 1'b0;
                r_req.write  <= 1'b0;
                r_last_grant <= (r_state == SERVE_I) ? PORT_I : PORT_D;
            end
        end
    end

    assign mem_read        = r_req.read;
    assign mem_write       = r_req.write;
    assign mem_byte_enable = r_req.byte_enable;
    assign mem_address     = r_req.address;
    assign mem_wdata       = r_req.wdata;
    assign i_mem_rdata     = mem_rdata;
    assign d_mem_rdata     = mem_rdata;
endmodule
